// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: state encoding and
// sign helpers that work on a wide container and are sliced by the caller.
package div_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    // Widest operand the helpers can carry; callers extend into this and slice back.
    localparam int MAXW = 64;
    typedef logic [MAXW-1:0] wide_t;

    // Magnitude of a value; the caller sign-extends in signed mode, so the MSB is the sign.
    function automatic wide_t abs_val(input wide_t value, input logic signed_mode);
        return (signed_mode && value[MAXW-1]) ? wide_t'(-value) : value;
    endfunction

    // Two's-complement negate when flag is set; low bits are correct at any width.
    function automatic wide_t neg_if(input wide_t value, input logic flag);
        return flag ? wide_t'(-value) : value;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract
// the divisor, keep the difference only when it does not go negative.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   prem,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   prem_nxt,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // prem[WIDTH] set means the true shifted value exceeds WIDTH+1 bits, which is
    // always >= divisor; the truncated difference is still the exact remainder.
    always_comb begin
        shifted  = {prem[WIDTH-1:0], bit_in};
        diff     = shifted - {1'b0, divisor};
        q_bit    = prem[WIDTH] | (shifted >= {1'b0, divisor});
        prem_nxt = q_bit ? diff : shifted;
    end

endmodule

// File: rtl/div_restoring_n.sv
// Sequential restoring divider, WIDTH+1 cycles per operation, with signed
// mode, divide-by-zero and MIN/-1 overflow fast paths answered in one cycle.
module div_restoring_n
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state_q;
    logic [WIDTH-1:0] dvd_q;     // dividend magnitude, shifts out MSB-first, fills with quotient bits
    logic [WIDTH-1:0] dvs_q;     // divisor magnitude
    logic [WIDTH:0]   prem_q;
    logic [CW-1:0]    cnt_q;
    logic             q_neg_q;
    logic             r_neg_q;

    logic [WIDTH:0]   prem_nxt;
    logic             q_bit;
    logic             dd_neg, ds_neg, ovf_case, last_iter;
    wide_t            dd_ext, ds_ext, dd_abs_w, ds_abs_w, q_fix_w, r_fix_w;
    logic             unused_hi;

    // Operand magnitudes and signs for acceptance, sign fix-up for completion.
    always_comb begin
        dd_ext    = signed_mode ? wide_t'($signed(dividend)) : wide_t'(dividend);
        ds_ext    = signed_mode ? wide_t'($signed(divisor))  : wide_t'(divisor);
        dd_abs_w  = abs_val(dd_ext, signed_mode);
        ds_abs_w  = abs_val(ds_ext, signed_mode);
        dd_neg    = signed_mode & dividend[WIDTH-1];
        ds_neg    = signed_mode & divisor[WIDTH-1];
        ovf_case  = signed_mode && (dividend == MIN_V) && (divisor == '1);
        q_fix_w   = neg_if(wide_t'(dvd_q), q_neg_q);
        r_fix_w   = neg_if(wide_t'(prem_q[WIDTH-1:0]), r_neg_q);
        last_iter = (cnt_q == CW'(WIDTH - 1));
    end

    assign unused_hi = ^{dd_abs_w[MAXW-1:WIDTH], ds_abs_w[MAXW-1:WIDTH],
                         q_fix_w[MAXW-1:WIDTH], r_fix_w[MAXW-1:WIDTH]};

    div_step #(.WIDTH(WIDTH)) u_step (
        .prem     (prem_q),
        .bit_in   (dvd_q[WIDTH-1]),
        .divisor  (dvs_q),
        .prem_nxt (prem_nxt),
        .q_bit    (q_bit)
    );

    // Control FSM, iteration datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            prem_q      <= '0;
            cnt_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                            done        <= 1'b1;
                        end else if (ovf_case) begin
                            quotient    <= dividend;
                            remainder   <= '0;
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b1;
                            done        <= 1'b1;
                        end else begin
                            dvd_q   <= dd_abs_w[WIDTH-1:0];
                            dvs_q   <= ds_abs_w[WIDTH-1:0];
                            q_neg_q <= dd_neg ^ ds_neg;
                            r_neg_q <= dd_neg;
                            prem_q  <= '0;
                            cnt_q   <= '0;
                            busy    <= 1'b1;
                            state_q <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    prem_q <= prem_nxt;
                    dvd_q  <= {dvd_q[WIDTH-2:0], q_bit};
                    cnt_q  <= cnt_q + 1'b1;
                    if (last_iter) state_q <= ST_FIX;
                end
                ST_FIX: begin
                    quotient    <= q_fix_w[WIDTH-1:0];
                    remainder   <= r_fix_w[WIDTH-1:0];
                    div_by_zero <= 1'b0;
                    overflow    <= 1'b0;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
